// File: rtl/imem_dmem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU.
// Round-robin with hold-until-granted lock; an in-order ID FIFO routes responses.
module imem_dmem_port_arbiter #(
  parameter int WORD_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   instr_req_i,
  input  logic [WORD_WIDTH-1:0]                  instr_addr_i,
  output logic                                   instr_gnt_o,
  output logic                                   instr_rvalid_o,
  output logic [WORD_WIDTH-1:0]                  instr_rdata_o,
  input  logic                                   data_req_i,
  input  logic [WORD_WIDTH-1:0]                  data_addr_i,
  input  logic                                   data_we_i,
  input  logic [3:0]                             data_be_i,
  input  logic [WORD_WIDTH-1:0]                  data_wdata_i,
  output logic                                   data_gnt_o,
  output logic                                   data_rvalid_o,
  output logic [WORD_WIDTH-1:0]                  data_rdata_o,
  output logic                                   mem_req_o,
  output logic [WORD_WIDTH-1:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [3:0]                             mem_be_o,
  output logic [WORD_WIDTH-1:0]                  mem_wdata_o,
  input  logic                                   mem_gnt_i,
  input  logic                                   mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0]                  mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    ID_INSTR = 1'b0,
    ID_DATA  = 1'b1
  } req_id_e;

  logic             lock_reg;
  req_id_e          lock_owner_reg;
  req_id_e          last_grant_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             err_reg;
  req_id_e          id_mem [MAX_OUTSTANDING];

  req_id_e          sel;
  req_id_e          head_id;
  logic             sel_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             grant;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;

  always_comb begin
    sel = ID_INSTR;
    if (lock_reg) begin
      sel = lock_owner_reg;
    end else if (instr_req_i && !data_req_i) begin
      sel = ID_INSTR;
    end else if (data_req_i && !instr_req_i) begin
      sel = ID_DATA;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_grant_reg == ID_DATA) ? ID_INSTR : ID_DATA;
    end
  end

  // Fullness comes from the registered count so rvalid never feeds mem_req_o.
  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign sel_req    = (sel == ID_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o  = rst_n && sel_req && !fifo_full;
  assign grant      = mem_req_o && mem_gnt_i;

  assign instr_gnt_o = grant && (sel == ID_INSTR);
  assign data_gnt_o  = grant && (sel == ID_DATA);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == ID_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = 4'hF;
      end
    end
  end

  assign head_id        = id_mem[rd_ptr_reg];
  assign pop            = rst_n && mem_rvalid_i && !fifo_empty;
  assign instr_rvalid_o = pop && (head_id == ID_INSTR);
  assign data_rvalid_o  = pop && (head_id == ID_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign outstanding_o  = count_reg;
  assign err_o          = err_reg;

  assign wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
  assign rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);

  // ID storage carries no reset; validity is tracked entirely by count_reg.
  always_ff @(posedge clk) begin
    if (grant) begin
      id_mem[wr_ptr_reg] <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg       <= 1'b0;
      lock_owner_reg <= ID_INSTR;
      last_grant_reg <= ID_DATA;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (grant) begin
        lock_reg       <= 1'b0;
        last_grant_reg <= sel;
        wr_ptr_reg     <= wr_ptr_next;
      end else if (mem_req_o) begin
        lock_reg       <= 1'b1;
        lock_owner_reg <= sel;
      end

      if (pop) begin
        rd_ptr_reg <= rd_ptr_next;
      end

      case ({grant, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      if (mem_rvalid_i && fifo_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_imem_dmem_port_arbiter;

  localparam logic [1:0] ID_I = 2'b10;
  localparam logic [1:0] ID_D = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  outstanding_o;
  logic        err_o;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  imem_dmem_port_arbiter #(.WORD_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [1:0] id, input logic [31:0] d);
    exp_t e;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    e.id   = id;
    e.data = d;
    sb_q.push_back(e);
    $display("resp issued id=%b data=0x%08h", id, d);
  endtask

  // Every expected response is issued in the same cycle it should appear.
  always @(negedge clk) begin
    if (instr_rvalid_o || data_rvalid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected actual=%b%b expected=none", instr_rvalid_o, data_rvalid_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rvalid_route", {30'd0, instr_rvalid_o, data_rvalid_o}, {30'd0, mon_e.id});
        chk("rvalid_rdata", instr_rvalid_o ? instr_rdata_o : data_rdata_o, mon_e.data);
        $display("rvalid seen id=%b%b data=0x%08h", instr_rvalid_o, data_rvalid_o, mon_e.data);
      end
    end else if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL rvalid_missing actual=none expected_id=%b", mon_e.id);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_addr_i = 32'h0; data_we_i = 1'b0;
    data_be_i = 4'h0; data_wdata_i = 32'h0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset state, with a request pending to prove gating.
    repeat (2) next_cyc();
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_instr_gnt", 32'(instr_gnt_o), 32'd0);
    next_cyc();
    rst_n = 1'b1; instr_req_i = 1'b0; mem_gnt_i = 1'b0;

    // 1: round robin, response one cycle after each grant.
    instr_addr_i = 32'h1000; data_addr_i = 32'h2000; data_be_i = 4'h3;
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
      if (i > 0) resp(((i - 1) % 2 == 0) ? ID_I : ID_D, 32'hA0 + 32'(i - 1));
      else mem_rvalid_i = 1'b0;
      #1;
      $display("rr cycle %0d instr_gnt=%b data_gnt=%b addr=0x%08h", i, instr_gnt_o, data_gnt_o, mem_addr_o);
      chk("rr_instr_gnt", 32'(instr_gnt_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_data_gnt", 32'(data_gnt_o), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_addr", mem_addr_o, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      chk("rr_be", 32'(mem_be_o), (i % 2 == 0) ? 32'hF : 32'h3);
      chk("rr_outstanding", 32'(outstanding_o), (i == 0) ? 32'd0 : 32'd1);
    end
    next_cyc();
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
    resp(ID_D, 32'hA3);
    #1;
    chk("rr_tail_outstanding", 32'(outstanding_o), 32'd1);
    chk("idle_mem_req", 32'(mem_req_o), 32'd0);
    next_cyc();
    mem_rvalid_i = 1'b0;
    #1;
    chk("rr_drained", 32'(outstanding_o), 32'd0);
    chk("idle_addr_zero", mem_addr_o, 32'h0);

    // 2: lock holds a stalled write while fetch arrives.
    instr_addr_i = 32'h3000;
    data_addr_i = 32'h100; data_we_i = 1'b1; data_be_i = 4'hC; data_wdata_i = 32'h55AA;
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      data_req_i = 1'b1;
      instr_req_i = (c >= 2);
      mem_gnt_i = (c == 4);
      #1;
      $display("lock cycle %0d addr=0x%08h data_gnt=%b instr_gnt=%b", c, mem_addr_o, data_gnt_o, instr_gnt_o);
      chk("lock_addr", mem_addr_o, 32'h100);
      chk("lock_we", 32'(mem_we_o), 32'd1);
      chk("lock_data_gnt", 32'(data_gnt_o), (c == 4) ? 32'd1 : 32'd0);
      chk("lock_instr_gnt", 32'(instr_gnt_o), 32'd0);
      if (c == 1) begin
        chk("lock_wdata", mem_wdata_o, 32'h55AA);
        chk("lock_be", 32'(mem_be_o), 32'hC);
      end
    end
    next_cyc();
    data_req_i = 1'b0; instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    resp(ID_D, 32'h0);
    #1;
    chk("after_lock_instr_gnt", 32'(instr_gnt_o), 32'd1);
    chk("fetch_addr", mem_addr_o, 32'h3000);
    chk("fetch_we", 32'(mem_we_o), 32'd0);
    chk("fetch_be", 32'(mem_be_o), 32'hF);
    chk("fetch_wdata", mem_wdata_o, 32'h0);
    next_cyc();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    resp(ID_I, 32'h11);
    next_cyc();
    mem_rvalid_i = 1'b0;
    #1;
    chk("lock_drained", 32'(outstanding_o), 32'd0);

    // 3 + 4: fill to MAX_OUTSTANDING, then a same-cycle grant and pop.
    instr_addr_i = 32'h4000; data_addr_i = 32'h5000; data_we_i = 1'b0; data_be_i = 4'hF;
    next_cyc();
    instr_req_i = 1'b1; data_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    chk("fill_instr_gnt", 32'(instr_gnt_o), 32'd1);
    next_cyc();
    data_req_i = 1'b1;
    #1;
    chk("fill_data_gnt", 32'(data_gnt_o), 32'd1);
    chk("fill_outstanding1", 32'(outstanding_o), 32'd1);
    for (int k = 0; k < 2; k++) begin
      next_cyc();
      #1;
      chk("full_mem_req", 32'(mem_req_o), 32'd0);
      chk("full_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
      chk("full_outstanding", 32'(outstanding_o), 32'd2);
    end
    next_cyc();
    resp(ID_I, 32'hDEADBEEF);
    #1;
    chk("full_pop_no_req", 32'(mem_req_o), 32'd0);
    chk("full_pop_no_gnt", 32'(instr_gnt_o), 32'd0);
    next_cyc();
    resp(ID_D, 32'hBEEF0001);
    #1;
    chk("regrant_instr_gnt", 32'(instr_gnt_o), 32'd1);
    chk("same_cycle_outstanding", 32'(outstanding_o), 32'd1);
    next_cyc();
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
    resp(ID_I, 32'hBEEF0002);
    #1;
    chk("push_pop_count_kept", 32'(outstanding_o), 32'd1);
    next_cyc();
    mem_rvalid_i = 1'b0;
    #1;
    chk("fill_drained", 32'(outstanding_o), 32'd0);

    // 5: stray response with nothing outstanding.
    next_cyc();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    #1;
    chk("pre_err_clear", 32'(err_o), 32'd0);
    next_cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
    #1;
    chk("stray_no_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    next_cyc();
    mem_rvalid_i = 1'b0;
    #1;
    chk("err_set", 32'(err_o), 32'd1);
    repeat (3) next_cyc();
    chk("err_sticky", 32'(err_o), 32'd1);

    // 6: asynchronous reset with two transactions in flight.
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    #1;
    chk("err_cleared_by_reset", 32'(err_o), 32'd0);
    next_cyc();
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    #1;
    chk("r6_instr_gnt", 32'(instr_gnt_o), 32'd1);
    next_cyc();
    #1;
    chk("r6_data_gnt", 32'(data_gnt_o), 32'd1);
    next_cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    #1;
    chk("r6_pre_reset_rvalid", 32'(instr_rvalid_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("r6_rvalid_drop", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    chk("r6_gnt_drop", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
    chk("r6_mem_req_drop", 32'(mem_req_o), 32'd0);
    chk("r6_outstanding", 32'(outstanding_o), 32'd0);
    mem_rvalid_i = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    #1;
    chk("r6_tie_instr", 32'(instr_gnt_o), 32'd1);
    chk("r6_tie_data", 32'(data_gnt_o), 32'd0);
    next_cyc();
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
    resp(ID_I, 32'h77);
    #1;
    chk("r6_outstanding1", 32'(outstanding_o), 32'd1);
    next_cyc();
    mem_rvalid_i = 1'b0;
    #1;
    chk("r6_drained", 32'(outstanding_o), 32'd0);
    chk("r6_err", 32'(err_o), 32'd0);

    next_cyc();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-ported memory bus (req/gnt/rvalid protocol) between two requesters: the fetch stage (read-only) and the load/store unit (read/write).
- Round-robin arbitration, with a hold-until-granted lock.
- Tracks outstanding transactions in an in-order ID FIFO so each rvalid/rdata is routed to the requester that issued it.
- Sits between the core front/back end and the unified memory interface.

Parameters:
WORD_WIDTH, 32, address/data width.
MAX_OUTSTANDING, 2, depth of the outstanding-transaction FIFO (power of two, >=1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_req_i  in  1  fetch request; held until instr_gnt_o.
instr_addr_i  in  WORD_WIDTH  fetch address.
instr_gnt_o  out  1  fetch request accepted this cycle.
instr_rvalid_o  out  1  instr_rdata_o valid this cycle.
instr_rdata_o  out  WORD_WIDTH  fetched word.
data_req_i  in  1  LSU request; held until data_gnt_o.
data_addr_i  in  WORD_WIDTH  LSU address.
data_we_i  in  1  1 = write.
data_be_i  in  4  byte enables.
data_wdata_i  in  WORD_WIDTH  write data.
data_gnt_o  out  1  LSU request accepted.
data_rvalid_o  out  1  LSU response valid (reads and writes).
data_rdata_o  out  WORD_WIDTH  read data.
mem_req_o  out  1  request to memory.
mem_addr_o  out  WORD_WIDTH  address to memory.
mem_we_o  out  1  write enable (0 for fetch).
mem_be_o  out  4  byte enables (4'hF for fetch).
mem_wdata_o  out  WORD_WIDTH  write data (0 for fetch).
mem_gnt_i  in  1  memory accepted request.
mem_rvalid_i  in  1  memory response valid.
mem_rdata_i  in  WORD_WIDTH  memory read data.
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count.
err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0): ID FIFO empty, outstanding_o=0, lock cleared, last_grant=DATA (fetch wins the first tie), err_o=0. All gnt/rvalid outputs are 0 and mem_req_o=0 while in reset.
- Arbitration (combinational on current state):
  - If lock is set, sel = locked owner.
  - Else, if exactly one requester is active, sel = that requester.
  - Else, if both are active, sel = the requester not equal to last_grant.
- mem_req_o = (selected requester's req) && !fifo_full. The mem_* address/data/control fields mux from sel. The fetch path drives we=0, be=4'hF, wdata=0. When idle, fields are 0.
- Grant: x_gnt_o = mem_gnt_i && mem_req_o && (sel==x). The gnt is combinational from mem_gnt_i, so there is zero added latency.
- Lock:
  - Set when mem_req_o=1 and mem_gnt_i=0; lock owner = sel.
  - Cleared on the grant cycle.
  - Guarantees mem_addr_o stays stable until granted, as required by the memory protocol.
- On grant: push the owner ID into the FIFO and set last_grant = owner.
- Response:
  - On mem_rvalid_i with the FIFO non-empty, pop the head ID.
  - Assert the matching x_rvalid_o combinationally in the same cycle.
  - mem_rdata_i drives both rdata outputs unconditionally; consumers qualify with their rvalid.
- Simultaneous grant and rvalid in one cycle: push and pop both occur, and the count is unchanged.
  - When full, a same-cycle pop does NOT enable a grant. mem_req_o uses registered fullness to avoid a combinational rvalid→req path.
- FIFO full (outstanding == MAX_OUTSTANDING): mem_req_o=0, no gnt, requesters wait. The lock is not set while full.
- Protocol error: mem_rvalid_i with the FIFO empty sets err_o (sticky until reset), is ignored, and produces no rvalid output.
- Pointers wrap modulo MAX_OUTSTANDING. Count width is $clog2(MAX_OUTSTANDING+1).
- Requester dropping req before gnt is a protocol violation. The lock still holds owner selection; behaviour is otherwise undefined and not checked.
- Reset mid-transaction discards all in-flight IDs. Memory responses arriving after reset with an empty FIFO set err_o.

Test Plan:
1. Both request continuously, mem_gnt_i=1, rvalid one cycle after each gnt:
   - Grants alternate instr, data, instr, data starting with instr.
   - Each rvalid is routed to the issuer.
   - outstanding_o stays ≤1.
2. Data request at addr 0x100 with mem_gnt_i=0 for 3 cycles, while instr_req_i rises in cycle 2:
   - mem_addr_o holds 0x100 for all cycles.
   - data_gnt_o is asserted in cycle 4.
   - Instr is granted next.
3. MAX_OUTSTANDING=2, gnt always 1, no rvalid:
   - Two grants issue (instr, data).
   - mem_req_o=0 with outstanding_o=2.
   - A single rvalid returns instr_rvalid_o=1 with rdata 0xDEADBEEF; the next cycle a new grant is issued.
4. Same-cycle grant and rvalid at outstanding_o=1:
   - outstanding_o stays 1.
   - The popped ID is routed correctly and the pushed ID is queued behind it.
5. mem_rvalid_i pulse after reset with no requests:
   - err_o=1 and stays 1.
   - No x_rvalid_o.
6. Assert rst_n=0 asynchronously mid-cycle with 2 outstanding:
   - gnt/rvalid outputs drop immediately and outstanding_o=0.
   - After release, the first tie is granted to instr.
